// File: rtl/sdr_sps_dram_controller.sv
// Initiator-side controller for the SDR single-port DRAM array: host valid/ready
// front end, registered array strobes, and refresh scheduling that blocks host traffic.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting; services a pending refresh first, else accepts host
// WRITE   | Enable+Write+bus drive held for WRITE_CYCLES cycles
// READ    | Enable+Read held for READ_LATENCY cycles, data sampled at end
// REFRESH | Refresh held for REFRESH_CYCLES cycles, host held off
module sdr_sps_dram_controller #(
   parameter int ADDR_WIDTH       = 4,
   parameter int DATA_WIDTH       = 8,
   parameter int READ_LATENCY     = 2,
   parameter int WRITE_CYCLES     = 1,
   parameter int REFRESH_INTERVAL = 64,
   parameter int REFRESH_CYCLES   = 4
) (
   input  logic                  Clock,
   input  logic                  nReset,
   input  logic                  HostValid,
   output logic                  HostReady,
   input  logic                  HostWrite,
   input  logic [ADDR_WIDTH-1:0] HostAddress,
   input  logic [DATA_WIDTH-1:0] HostWriteData,
   output logic [DATA_WIDTH-1:0] HostReadData,
   output logic                  HostReadValid,
   output logic                  RefreshBusy,
   output logic [ADDR_WIDTH-1:0] DramAddress,
   output logic                  DramEnable,
   output logic                  DramRead,
   output logic                  DramWrite,
   output logic                  DramRefresh,
   output logic [DATA_WIDTH-1:0] DramDataOut,
   output logic                  DramDataOE,
   input  logic [DATA_WIDTH-1:0] DramDataIn
);

   localparam int PH_MAX = (READ_LATENCY > WRITE_CYCLES)
                         ? ((READ_LATENCY > REFRESH_CYCLES) ? READ_LATENCY : REFRESH_CYCLES)
                         : ((WRITE_CYCLES > REFRESH_CYCLES) ? WRITE_CYCLES : REFRESH_CYCLES);
   localparam int PH_W = $clog2(PH_MAX + 1);
   localparam int RC_W = $clog2(REFRESH_INTERVAL + 1);

   localparam logic [PH_W-1:0] WR_LOAD  = PH_W'(WRITE_CYCLES - 1);
   localparam logic [PH_W-1:0] RD_LOAD  = PH_W'(READ_LATENCY - 1);
   localparam logic [PH_W-1:0] REF_LOAD = PH_W'(REFRESH_CYCLES - 1);
   localparam logic [RC_W-1:0] RC_LAST  = RC_W'(REFRESH_INTERVAL - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITE   = 2'd1,
      READ    = 2'd2,
      REFRESH = 2'd3
   } state_t;

   state_t          state_q, state_nx;
   logic [PH_W-1:0] ph_cnt_q, ph_cnt_nx;
   logic [RC_W-1:0] ref_cnt_q;
   logic            ref_pend_q;
   logic            accept;
   logic            ref_wrap;
   logic            ref_start;
   logic            read_done;

   assign HostReady = (state_q == IDLE) && !ref_pend_q;
   assign accept    = HostValid && HostReady;
   assign ref_wrap  = (ref_cnt_q == RC_LAST);
   assign ref_start = (state_q == IDLE) && ref_pend_q;

   // Phase counter counts down to zero; the zero cycle is the last of the phase.
   always_comb begin
      state_nx  = state_q;
      ph_cnt_nx = ph_cnt_q;
      read_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (ref_pend_q) begin
               state_nx  = REFRESH;
               ph_cnt_nx = REF_LOAD;
            end else if (accept) begin
               if (HostWrite) begin
                  state_nx  = WRITE;
                  ph_cnt_nx = WR_LOAD;
               end else begin
                  state_nx  = READ;
                  ph_cnt_nx = RD_LOAD;
               end
            end
         end
         WRITE: begin
            if (ph_cnt_q == '0) state_nx = IDLE;
            else                ph_cnt_nx = ph_cnt_q - PH_W'(1);
         end
         READ: begin
            if (ph_cnt_q == '0) begin
               state_nx  = IDLE;
               read_done = 1'b1;
            end else begin
               ph_cnt_nx = ph_cnt_q - PH_W'(1);
            end
         end
         REFRESH: begin
            if (ph_cnt_q == '0) state_nx = IDLE;
            else                ph_cnt_nx = ph_cnt_q - PH_W'(1);
         end
         default: begin
            state_nx  = IDLE;
            ph_cnt_nx = '0;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q  <= IDLE;
         ph_cnt_q <= '0;
      end else begin
         state_q  <= state_nx;
         ph_cnt_q <= ph_cnt_nx;
      end
   end

   // A wrap while a request is already pending leaves it set; a wrap wins over the clear.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         ref_cnt_q  <= '0;
         ref_pend_q <= 1'b0;
      end else begin
         ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + RC_W'(1);
         if (ref_wrap)       ref_pend_q <= 1'b1;
         else if (ref_start) ref_pend_q <= 1'b0;
      end
   end

   // Strobes are decoded from the next state so they line up with the phase they belong to.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         DramEnable    <= 1'b0;
         DramRead      <= 1'b0;
         DramWrite     <= 1'b0;
         DramRefresh   <= 1'b0;
         DramDataOE    <= 1'b0;
         DramAddress   <= '0;
         DramDataOut   <= '0;
         RefreshBusy   <= 1'b0;
         HostReadData  <= '0;
         HostReadValid <= 1'b0;
      end else begin
         DramEnable    <= (state_nx == WRITE) || (state_nx == READ);
         DramRead      <= (state_nx == READ);
         DramWrite     <= (state_nx == WRITE);
         DramDataOE    <= (state_nx == WRITE);
         DramRefresh   <= (state_nx == REFRESH);
         RefreshBusy   <= (state_nx == REFRESH);
         HostReadValid <= read_done;
         if (accept) begin
            DramAddress <= HostAddress;
            if (HostWrite) DramDataOut <= HostWriteData;
         end
         if (read_done) HostReadData <= DramDataIn;
      end
   end

endmodule

// File: tb/tb_sdr_sps_dram_controller.sv
// Scoreboard bench for sdr_sps_dram_controller: a word-array model sits on the DRAM pins,
// expectations come from a host-level reference memory and refresh-period arithmetic.
module tb_sdr_sps_dram_controller;

   localparam int AW   = 4;
   localparam int DW   = 8;
   localparam int RL   = 2;
   localparam int WC   = 1;
   localparam int RI   = 64;
   localparam int RC   = 4;
   localparam int MAXT = (RL > WC) ? RL : WC;

   logic          Clock = 1'b0;
   logic          nReset = 1'b0;
   logic          HostValid, HostReady, HostWrite;
   logic [AW-1:0] HostAddress;
   logic [DW-1:0] HostWriteData, HostReadData;
   logic          HostReadValid, RefreshBusy;
   logic [AW-1:0] DramAddress;
   logic          DramEnable, DramRead, DramWrite, DramRefresh, DramDataOE;
   logic [DW-1:0] DramDataOut, DramDataIn;

   sdr_sps_dram_controller #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .WRITE_CYCLES(WC),
      .REFRESH_INTERVAL(RI), .REFRESH_CYCLES(RC)
   ) dut (
      .Clock(Clock), .nReset(nReset),
      .HostValid(HostValid), .HostReady(HostReady), .HostWrite(HostWrite),
      .HostAddress(HostAddress), .HostWriteData(HostWriteData),
      .HostReadData(HostReadData), .HostReadValid(HostReadValid),
      .RefreshBusy(RefreshBusy), .DramAddress(DramAddress), .DramEnable(DramEnable),
      .DramRead(DramRead), .DramWrite(DramWrite), .DramRefresh(DramRefresh),
      .DramDataOut(DramDataOut), .DramDataOE(DramDataOE), .DramDataIn(DramDataIn)
   );

   always #5 Clock = ~Clock;

   // Array model on the DRAM pins
   logic [DW-1:0] dram_mem [2**AW];
   assign DramDataIn = dram_mem[DramAddress];
   always @(posedge Clock) if (nReset && DramWrite) dram_mem[DramAddress] <= DramDataOut;

   int edge_cnt;
   always @(posedge Clock or negedge nReset)
      if (!nReset) edge_cnt <= 0;
      else         edge_cnt <= edge_cnt + 1;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           wr_q[$];
   logic [DW-1:0] rd_q[$];
   logic [DW-1:0] ref_mem [2**AW];
   bit            ref_valid [2**AW];
   int            tests = 0;
   int            fails = 0;
   int            burst_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int acc_edge);
      logic rdy;
      int   n;
      rdy = 1'b0;
      n = 0;
      acc_edge = -1;
      while (!rdy && n < 200) begin
         @(negedge Clock);
         HostValid = 1'b1; HostWrite = wr; HostAddress = a; HostWriteData = d;
         rdy = HostReady;
         acc_edge = edge_cnt + 1;
         n++;
         @(posedge Clock);
      end
      chk("issue_accepted", {31'd0, rdy}, 32'd1);
      if (rdy) begin
         if (wr) begin
            wr_q.push_back('{a: a, d: d});
            ref_mem[a] = d;
            ref_valid[a] = 1'b1;
         end else begin
            rd_q.push_back(ref_mem[a]);
         end
      end
   endtask

   task automatic host_idle();
      @(negedge Clock);
      HostValid = 1'b0;
      HostWrite = 1'($urandom_range(0, 1));
      HostAddress = AW'($urandom);
      HostWriteData = DW'($urandom);
   endtask

   // Monitor: pops expectations whenever the DUT presents a write strobe or read data.
   initial begin : monitor
      int  wr_len, rd_len, rf_len, d;
      wr_t e;
      wr_len = 0; rd_len = 0; rf_len = 0;
      forever begin
         @(negedge Clock);
         if (!nReset) begin
            wr_len = 0; rd_len = 0; rf_len = 0; burst_cnt = 0;
         end else begin
            if (DramRead || DramWrite || DramRefresh) begin
               chk("rd_wr_exclusive", {31'd0, DramRead && DramWrite}, 32'd0);
               chk("ref_en_exclusive", {31'd0, DramRefresh && DramEnable}, 32'd0);
            end
            if (DramWrite) begin
               if (wr_len == 0) begin
                  chk("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
                  if (wr_q.size() != 0) begin
                     e = wr_q.pop_front();
                     chk("wr_addr", 32'(DramAddress), 32'(e.a));
                     chk("wr_data", 32'(DramDataOut), 32'(e.d));
                  end
               end
               chk("wr_oe_en", {30'd0, DramDataOE, DramEnable}, 32'd3);
               wr_len++;
            end else if (wr_len != 0) begin
               chk("wr_len", wr_len, WC);
               wr_len = 0;
            end
            if (DramRead) begin
               if (rd_len == 0) chk("read_strobe_expected", {31'd0, rd_q.size() != 0}, 32'd1);
               chk("rd_oe_en", {30'd0, DramDataOE, DramEnable}, 32'd1);
               rd_len++;
            end else if (rd_len != 0) begin
               chk("rd_len", rd_len, RL);
               rd_len = 0;
            end
            if (HostReadValid) begin
               chk("read_expected", {31'd0, rd_q.size() != 0}, 32'd1);
               if (rd_q.size() != 0) chk("rd_data", 32'(HostReadData), 32'(rd_q.pop_front()));
            end
            if (DramRefresh) begin
               if (rf_len == 0) begin
                  burst_cnt++;
                  d = edge_cnt - RI * burst_cnt;
                  chk("ref_start_window", {31'd0, d >= 1 && d <= 1 + MAXT}, 32'd1);
               end
               chk("ref_busy_ready", {30'd0, RefreshBusy, HostReady}, 32'd2);
               rf_len++;
            end else if (rf_len != 0) begin
               chk("ref_len", rf_len, RC);
               rf_len = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int acc, prev_acc, prev_b, n;
      logic wr;
      logic [AW-1:0] a;
      HostValid = 1'b0; HostWrite = 1'b0; HostAddress = '0; HostWriteData = '0;
      for (int i = 0; i < 2**AW; i++) begin
         ref_mem[i] = '0;
         ref_valid[i] = 1'b0;
      end
      repeat (3) @(negedge Clock);
      chk("rst_ready", {31'd0, HostReady}, 32'd1);
      chk("rst_strobes", {26'd0, DramEnable, DramRead, DramWrite, DramRefresh, DramDataOE,
                          RefreshBusy}, 32'd0);
      chk("rst_read", {23'd0, HostReadValid, HostReadData}, 32'd0);
      chk("rst_bus", {20'd0, DramAddress, DramDataOut}, 32'd0);
      nReset = 1'b1;

      // Idle refresh timing after reset release
      repeat (RI - 1) @(posedge Clock);
      @(negedge Clock);
      chk("ready_before_wrap", {31'd0, HostReady}, 32'd1);
      @(negedge Clock);
      chk("ready_pending", {30'd0, HostReady, DramRefresh}, 32'd0);
      for (int i = 0; i < RC; i++) begin
         @(negedge Clock);
         chk("idle_ref_burst", {29'd0, DramRefresh, RefreshBusy, DramEnable}, 32'd6);
      end
      @(negedge Clock);
      chk("ready_after_ref", {30'd0, HostReady, DramRefresh}, 32'd2);

      // Read held high while refresh becomes pending
      issue(1'b1, 4'h7, 8'h3C, acc);
      host_idle();
      n = 0;
      while (edge_cnt < 2 * RI - 1 && n < 200) begin
         @(negedge Clock);
         n++;
      end
      issue(1'b0, 4'h7, 8'h00, acc);
      chk("read_after_refresh_edge", acc, 2 * RI + RC + 2);
      host_idle();
      repeat (RL + 2) @(negedge Clock);

      // Directed write timing
      issue(1'b1, 4'h3, 8'hA5, acc);
      @(negedge Clock);
      HostValid = 1'b0;
      chk("wr_strobes", {27'd0, DramEnable, DramWrite, DramDataOE, DramRead, HostReady},
          32'h1C);
      chk("wr_bus", {20'd0, DramAddress, DramDataOut}, 32'h3A5);
      @(negedge Clock);
      chk("wr_done", {28'd0, DramEnable, DramWrite, DramDataOE, HostReady}, 32'd1);

      // Directed read timing
      issue(1'b1, 4'h3, 8'h5A, acc);
      issue(1'b0, 4'h3, 8'h00, acc);
      for (int i = 0; i < RL; i++) begin
         @(negedge Clock);
         HostValid = 1'b0;
         chk("rd_strobes", {28'd0, DramEnable, DramRead, DramDataOE, HostReadValid}, 32'hC);
      end
      @(negedge Clock);
      chk("rd_valid", {22'd0, HostReadValid, HostReady, HostReadData}, 32'h35A);
      @(negedge Clock);
      chk("rd_valid_pulse", {31'd0, HostReadValid}, 32'd0);

      // Reset in the middle of a read
      issue(1'b0, 4'h3, 8'h00, acc);
      @(negedge Clock);
      HostValid = 1'b0;
      chk("rd_before_reset", {31'd0, DramRead}, 32'd1);
      #1 nReset = 1'b0;
      #1;
      chk("async_rst_strobes", {26'd0, DramEnable, DramRead, DramWrite, DramRefresh,
                                DramDataOE, HostReadValid}, 32'd0);
      chk("async_rst_ready", {30'd0, HostReady, RefreshBusy}, 32'd2);
      rd_q.delete();
      wr_q.delete();
      repeat (2) @(negedge Clock);
      nReset = 1'b1;
      @(negedge Clock);
      chk("ready_after_reset", {30'd0, HostReady, HostReadValid}, 32'd2);

      // Back-to-back writes across a refresh wrap
      n = 0;
      while (edge_cnt < RI - 14 && n < 200) begin
         @(negedge Clock);
         n++;
      end
      prev_acc = -1;
      prev_b = burst_cnt;
      for (int i = 0; i < 2**AW; i++) begin
         issue(1'b1, AW'(i), DW'($urandom), acc);
         if (prev_acc >= 0 && burst_cnt == prev_b) chk("b2b_gap", acc - prev_acc, WC + 1);
         prev_b = burst_cnt;
         prev_acc = acc;
      end
      host_idle();
      chk("b2b_saw_refresh", {31'd0, burst_cnt >= 1}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         a = AW'($urandom);
         wr = 1'($urandom_range(0, 1));
         if (!ref_valid[a]) wr = 1'b1;
         issue(wr, a, DW'($urandom), acc);
         if ($urandom_range(0, 3) == 0) begin
            host_idle();
            repeat ($urandom_range(0, 3)) @(negedge Clock);
         end
      end
      host_idle();
      n = 0;
      while ((rd_q.size() != 0 || wr_q.size() != 0) && n < 100) begin
         @(negedge Clock);
         n++;
      end
      chk("drain", rd_q.size() + wr_q.size(), 0);
      repeat (4) @(negedge Clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
